fib_byte_serializer: RTL and testbench



---
 rtl/fib_byte_serializer_if.sv | 23 ++
 rtl/fib_byte_serializer.sv | 148 ++++++++++++++
 tb/tb_fib_byte_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fib_byte_serializer_if.sv
// rtl/fib_byte_serializer_if.sv - handshake, skip and display signals of the Fibonacci byte serializer
interface fib_byte_serializer_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        skip;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic [2:0]  out_index;
  logic        out_last;
  logic        done_tick;
  logic        busy;

  modport master (
    output in_valid, in_data, skip,
    input  in_ready, out_byte, out_valid, out_index, out_last, done_tick, busy
  );

  modport slave (
    input  in_valid, in_data, skip,
    output in_ready, out_byte, out_valid, out_index, out_last, done_tick, busy
  );
endinterface

// File: rtl/fib_byte_serializer.sv
// rtl/fib_byte_serializer.sv - shows a 64-bit value MS byte first, significant bytes only, each for a dwell time
// Optional inter-byte blanking gap enabled by defining FIB_SER_BLANK_EN.
module fib_byte_serializer #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  fib_byte_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIZE,
    ST_SHOW,
`ifdef FIB_SER_BLANK_EN
    ST_GAP,
`endif
    ST_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef FIB_SER_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  state_t           state;
  logic [63:0]      data_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       top_idx;
  logic [2:0]       next_idx;

  function automatic logic [7:0] sel_byte(input logic [63:0] d, input logic [2:0] i);
    return d[{i, 3'b000} +: 8];
  endfunction

  // Highest nonzero byte; an all-zero value still shows byte 0.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (data_q[i*8 +: 8] != 8'd0) begin
        top_idx = 3'(i);
      end
    end
  end

  assign next_idx = idx_q - 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      data_q        <= 64'd0;
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_byte  <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.out_index <= 3'd0;
      bus.out_last  <= 1'b0;
      bus.done_tick <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done_tick <= 1'b0;
          if (bus.in_valid) begin
            data_q       <= bus.in_data;
            state        <= ST_SIZE;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end

        ST_SIZE: begin
          idx_q         <= top_idx;
          cnt_q         <= '0;
          state         <= ST_SHOW;
          bus.out_valid <= 1'b1;
          bus.out_byte  <= sel_byte(data_q, top_idx);
          bus.out_index <= top_idx;
          bus.out_last  <= (top_idx == 3'd0);
        end

        ST_SHOW: begin
          // skip and dwell expiry together still advance only once
          if (bus.skip || cnt_q == DWELL_LAST) begin
            cnt_q <= '0;
            if (idx_q == 3'd0) begin
              state         <= ST_FINISH;
              bus.done_tick <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_byte  <= 8'd0;
              bus.out_last  <= 1'b0;
            end else begin
              idx_q         <= next_idx;
              bus.out_index <= next_idx;
`ifdef FIB_SER_BLANK_EN
              state         <= ST_GAP;
              bus.out_valid <= 1'b0;
              bus.out_byte  <= 8'd0;
              bus.out_last  <= 1'b0;
`else
              bus.out_byte  <= sel_byte(data_q, next_idx);
              bus.out_last  <= (next_idx == 3'd0);
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef FIB_SER_BLANK_EN
        ST_GAP: begin
          if (bus.skip || cnt_q == BLANK_LAST) begin
            cnt_q         <= '0;
            state         <= ST_SHOW;
            bus.out_valid <= 1'b1;
            bus.out_byte  <= sel_byte(data_q, idx_q);
            bus.out_last  <= (idx_q == 3'd0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        ST_FINISH: begin
          state         <= ST_IDLE;
          bus.done_tick <= 1'b0;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          bus.out_index <= 3'd0;
        end

        default: begin
          state         <= ST_IDLE;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.out_byte  <= 8'd0;
          bus.done_tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_byte_serializer.sv
// tb/tb_fib_byte_serializer.sv - self-checking bench for fib_byte_serializer
module tb_fib_byte_serializer;
  localparam int DW = 4;
  localparam int BL = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fib_byte_serializer_if bus();

  fib_byte_serializer #(.DWELL_CYCLES(DW), .CNT_W(8), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic       valid;
    logic [7:0] b;
    logic [2:0] idx;
    logic       chk_idx;
    logic       last;
    logic       done;
    logic       ready;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       valid;
    logic [7:0] b;
    logic [2:0] idx;
    int         len;
  } seg_t;

  typedef struct {
    logic [63:0]  value;
    logic [127:0] mask;
    bit           inject;
    int           done_at;
    string        name;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t trace[$];
  exp_t idle_rec;

  // Expected per-cycle view: SIZE cycle, then display segments cut short by skip, then FINISH and IDLE.
  function automatic void build(input logic [63:0] v, input logic [127:0] mask);
    seg_t segs[$];
    int   n;
    int   c;
    n = 1;
    for (int i = 0; i < 8; i++) if (v[i*8 +: 8] != 8'd0) n = i + 1;
    for (int i = n - 1; i >= 0; i--) begin
      segs.push_back('{1'b1, v[i*8 +: 8], 3'(i), DW});
`ifdef FIB_SER_BLANK_EN
      if (i > 0) segs.push_back('{1'b0, 8'h00, 3'(i - 1), BL});
`endif
    end
    trace.delete();
    trace.push_back('{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    c = 1;
    foreach (segs[s]) begin
      for (int k = 0; k < segs[s].len; k++) begin
        trace.push_back('{segs[s].valid, segs[s].b, segs[s].idx, 1'b1,
                          segs[s].valid && (segs[s].idx == 3'd0), 1'b0, 1'b0, 1'b1});
        c++;
        if (mask[c-1]) break;
      end
    end
    trace.push_back('{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    trace.push_back('{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
  endfunction

  task automatic compare(input exp_t e, input string name, input int c);
    logic ok;
    ok = (bus.out_valid === e.valid) && (bus.out_byte === e.b) && (bus.done_tick === e.done) &&
         (bus.in_ready === e.ready) && (bus.busy === e.busy);
    if (e.chk_idx) ok = ok && (bus.out_index === e.idx);
    if (e.valid)   ok = ok && (bus.out_last === e.last);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle %0d: got valid=%0b byte=%02h idx=%0d last=%0b done=%0b ready=%0b busy=%0b, expected valid=%0b byte=%02h idx=%0d last=%0b done=%0b ready=%0b busy=%0b",
               name, c, bus.out_valid, bus.out_byte, bus.out_index, bus.out_last, bus.done_tick,
               bus.in_ready, bus.busy, e.valid, e.b, e.idx, e.last, e.done, e.ready, e.busy);
    end
  endtask

  // Capture at edge T, then trace[c] is sampled in cycle T+c+1; skip driven in cycle c is seen at the following edge.
  task automatic run_vec(input logic [63:0] v, input logic [127:0] mask, input bit inject,
                         input int done_at, input string name);
    int done_seen;
    build(v, mask);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.skip     = 1'($urandom_range(0, 1));
    done_seen    = -1;
    for (int c = 0; c < trace.size(); c++) begin
      @(negedge clk);
      compare(trace[c], name, c);
      if (bus.done_tick === 1'b1 && done_seen < 0) done_seen = c;
      bus.skip     = mask[c];
      bus.in_valid = inject && (c < trace.size() - 1);
      bus.in_data  = inject ? 64'h55 : v;
    end
    bus.skip     = 1'b0;
    bus.in_valid = 1'b0;
    if (done_at > 0) begin
      checks++;
      if (done_seen + 1 != done_at) begin
        errors++;
        $display("FAIL %s done_time: got T+%0d, expected T+%0d", name, done_seen + 1, done_at);
      end
    end
  endtask

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64'h179, 128'h0, 1'b0, 10, "v377"};
    vecs[1] = '{64'h0, 128'h0, 1'b0, 6, "vzero"};
    vecs[2] = '{64'hDEC1139639, 128'h0, 1'b0, 22, "vdec"};
    vecs[3] = '{64'hDEC1139639, 128'h3E, 1'b1, 7, "vdec_skip"};
`ifdef FIB_SER_BLANK_EN
    vecs[0].done_at = 12;
    vecs[2].done_at = 30;
    vecs[3].mask    = 128'h3FE;
    vecs[3].done_at = 11;
`endif
    idle_rec = '{1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h1234;
    bus.skip     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare(idle_rec, "reset_state", 0);
    checks++;
    if (bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_last: got %0b, expected 0", bus.out_last);
    end
    bus.in_valid = 1'b0;
    bus.skip     = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    compare(idle_rec, "idle_after_reset", 0);

    foreach (vecs[i]) run_vec(vecs[i].value, vecs[i].mask, vecs[i].inject, vecs[i].done_at, vecs[i].name);

    // Reset while the second byte of 0x179 is on display.
    build(64'h179, 128'h0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h179;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      compare(trace[c], "pre_reset", c);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    compare(idle_rec, "mid_reset", 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      compare(idle_rec, "post_reset_idle", c);
    end
    run_vec(64'h179, 128'h0, 1'b0, vecs[0].done_at, "after_reset");

    // Same value with skip coinciding with natural dwell expiry: single advance.
    begin
      logic [127:0] m;
      m = '0;
      m[4] = 1'b1;
      run_vec(64'h179, m, 1'b0, vecs[0].done_at, "skip_at_expiry");
    end

    for (int r = 0; r < 16; r++) begin
      logic [63:0]  v;
      logic [127:0] m;
      int           nb;
      nb = $urandom_range(1, 8);
      v  = {$urandom(), $urandom()};
      if (nb < 8) v = v & ((64'd1 << (8 * nb)) - 64'd1);
      if ($urandom_range(0, 7) == 0) v = 64'd0;
      for (int b = 0; b < 128; b++) m[b] = ($urandom_range(0, 4) == 0);
      run_vec(v, m, 1'($urandom_range(0, 1)), 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
